jump_ctrl: RTL

JUMP_CTRL -- requirements
Module: jump_ctrl

---
 rtl/jump_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/jump_ctrl.sv
// Game controller for a bouncing-ball platformer: start/run/over sequencing,
// landing detection against one platform, score keeping and speed level-up.
module jump_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_start,
   input  logic [9:0] ball_x,
   input  logic [8:0] ball_y,
   input  logic       ball_dir,
   input  logic [9:0] plat_x,
   input  logic [6:0] plat_w,
   input  logic [8:0] plat_y,
   output logic       bounce_start,
   output logic [3:0] max_speed,
   output logic [9:0] score,
   output logic       land_pulse,
   output logic       game_over,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_OVER = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   localparam logic [9:0] SCORE_MAX = 10'd999;
   localparam logic [8:0] FLOOR_Y   = 9'd470;
   localparam logic [3:0] SPEED_MIN = 4'd7;
   localparam logic [3:0] SPEED_MAX = 4'd10;

   state_t      state_q, state_d;
   logic [9:0]  score_q, score_d;
   logic [3:0]  speed_q, speed_d;
   logic        landed_q, landed_d;
   logic        land_q, land_d;
   logic        btn_q;
   logic        bounce_q;
   logic        over_q;

   // Geometry is widened to 11 bits so edge sums never wrap.
   logic [10:0] ball_l, ball_r, ball_b;
   logic [10:0] plat_l, plat_r, win_top, win_bot;
   logic        in_x, in_y;
   logic        start_edge;
   logic        falling;
   logic        fall_out;
   logic        landing;
   logic [9:0]  score_inc;

   assign ball_l  = {1'b0, ball_x};
   assign ball_r  = {1'b0, ball_x} + 11'd16;
   assign ball_b  = {2'b00, ball_y};
   assign plat_l  = {1'b0, plat_x};
   assign plat_r  = {1'b0, plat_x} + {4'b0000, plat_w};
   assign win_top = {2'b00, plat_y};
   assign win_bot = {2'b00, plat_y} + 11'd15;

   assign in_x       = (ball_r > plat_l) && (ball_l < plat_r);
   assign in_y       = (ball_b >= win_top) && (ball_b <= win_bot);
   assign start_edge = btn_start && !btn_q;
   assign falling    = tick && !ball_dir;
   assign fall_out   = falling && (ball_y >= FLOOR_Y);
   assign landing    = falling && !landed_q && in_x && in_y;
   assign score_inc  = score_q + 10'd1;

   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      speed_d  = speed_q;
      landed_d = landed_q;
      land_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d  = ST_RUN;
               score_d  = 10'd0;
               speed_d  = SPEED_MIN;
               landed_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (tick) begin
               // Falling off the bottom beats a simultaneous landing.
               if (fall_out) begin
                  state_d = ST_OVER;
               end else if (landing) begin
                  landed_d = 1'b1;
                  land_d   = 1'b1;
                  if (score_q != SCORE_MAX) begin
                     score_d = score_inc;
                     if ((score_inc[2:0] == 3'b000) && (speed_q < SPEED_MAX))
                        speed_d = speed_q + 4'd1;
                  end
               end else if (ball_dir) begin
                  landed_d = 1'b0;
               end
            end
         end
         ST_OVER: begin
            if (start_edge)
               state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         score_q  <= 10'd0;
         speed_q  <= SPEED_MIN;
         landed_q <= 1'b0;
         land_q   <= 1'b0;
         btn_q    <= 1'b1;
         bounce_q <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         score_q  <= score_d;
         speed_q  <= speed_d;
         landed_q <= landed_d;
         land_q   <= land_d;
         btn_q    <= btn_start;
         bounce_q <= (state_d == ST_RUN);
         over_q   <= (state_d == ST_OVER);
      end
   end

   assign state        = state_q;
   assign score        = score_q;
   assign max_speed    = speed_q;
   assign land_pulse   = land_q;
   assign bounce_start = bounce_q;
   assign game_over    = over_q;

endmodule
